// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Largest value representable in ndig decimal digits (10^ndig - 1).
  function automatic longint unsigned max_dec(input int ndig);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < ndig; i++) begin
      acc = acc * 64'd10;
    end
    return acc - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Pre-shift correction so the following left shift carries into the next digit.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with an overflow indication that blanks all digits.
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*NDIG-1:0] bcd,
  output logic                    ovf
);

  localparam int                       CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(BIN_W - 1);
  localparam longint unsigned          MAX_VAL  = max_dec(NDIG);
  localparam int                       SCR_W    = DIGIT_W * NDIG;

  state_e             state_r;
  logic [BIN_W-1:0]   shreg_r;
  logic [SCR_W-1:0]   scratch_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_pend_r;

  logic [SCR_W-1:0]   adj_s;
  logic [SCR_W-1:0]   scratch_nxt_s;
  logic [BIN_W-1:0]   shreg_nxt_s;
  logic               accept_s;
  logic               start_ovf_s;

  // One add-3 corrector per decimal digit of the scratch register.
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (scratch_r[g*DIGIT_W +: DIGIT_W]),
      .dout (adj_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Next shift step, start acceptance and overflow decision on the incoming value.
  always_comb begin
    scratch_nxt_s = {adj_s[SCR_W-2:0], shreg_r[BIN_W-1]};
    shreg_nxt_s   = {shreg_r[BIN_W-2:0], 1'b0};
    accept_s      = start && (state_r != ST_SHIFT);
    if (64'(bin) > MAX_VAL) begin
      start_ovf_s = 1'b1;
    end else begin
      start_ovf_s = 1'b0;
    end
  end

  // Conversion FSM with registered busy/done and result outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      scratch_r  <= '0;
      cnt_r      <= '0;
      ovf_pend_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            state_r    <= ST_SHIFT;
            shreg_r    <= bin;
            scratch_r  <= '0;
            cnt_r      <= '0;
            ovf_pend_r <= start_ovf_s;
            busy       <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          scratch_r <= scratch_nxt_s;
          shreg_r   <= shreg_nxt_s;
          cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            // Last shift: publish the result on the edge that enters DONE.
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            ovf     <= ovf_pend_r;
            if (ovf_pend_r) begin
              bcd <= {NDIG{BCD_BLANK}};
            end else begin
              bcd <= scratch_nxt_s;
            end
          end else begin
            state_r <= ST_SHIFT;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd (default BIN_W=14, NDIG=4).
module tb_bin_to_bcd;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int total;
  int bad;

  bin_to_bcd #(.BIN_W(14), .NDIG(4)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Start one conversion and wait (bounded) for done; no checking here.
  task automatic do_conv(input logic [13:0] v, output int lat, output int bcnt,
                         output logic [15:0] rb, output logic ro, output bit tmo);
    lat  = 0;
    bcnt = 0;
    tmo  = 1'b0;
    @(negedge clock);
    start = 1'b1;
    bin   = v;
    @(posedge clock); #1;
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clock); #1;
      lat++;
    end
    if (done !== 1'b1) tmo = 1'b1;
    rb = bcd;
    ro = ovf;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = 14'd0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    int lat, bcnt; logic [15:0] rb; logic ro; bit tmo;
    do_conv(14'd0, lat, bcnt, rb, ro, tmo);
    total++; if (tmo) begin bad++; $display("FAIL zero_timeout got=no_done exp=done"); end
    total++; if (lat !== 15) begin bad++; $display("FAIL zero_latency got=%0d exp=15", lat); end
    total++; if (bcnt !== 14) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=14", bcnt); end
    total++; if (rb !== 16'h0000) begin bad++; $display("FAIL zero_bcd got=%h exp=0000", rb); end
    total++; if (ro !== 1'b0) begin bad++; $display("FAIL zero_ovf got=%0b exp=0", ro); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_in_done got=%0b exp=0", busy); end
    @(posedge clock); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%0b exp=0", done); end
    total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL zero_bcd_hold got=%h exp=0000", bcd); end
  endtask

  task automatic test_values;
    logic [13:0] vin [3];
    logic [15:0] vexp [3];
    int lat, bcnt; logic [15:0] rb; logic ro; bit tmo;
    vin[0] = 14'd1234; vexp[0] = 16'h1234;
    vin[1] = 14'd9999; vexp[1] = 16'h9999;
    vin[2] = 14'd5;    vexp[2] = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      do_conv(vin[i], lat, bcnt, rb, ro, tmo);
      total++; if (tmo) begin bad++; $display("FAIL val_timeout bin=%0d got=no_done exp=done", vin[i]); end
      total++; if (rb !== vexp[i]) begin bad++; $display("FAIL val_bcd bin=%0d got=%h exp=%h", vin[i], rb, vexp[i]); end
      total++; if (ro !== 1'b0) begin bad++; $display("FAIL val_ovf bin=%0d got=%0b exp=0", vin[i], ro); end
      total++; if (lat !== 15) begin bad++; $display("FAIL val_latency bin=%0d got=%0d exp=15", vin[i], lat); end
    end
  endtask

  task automatic test_overflow;
    logic [13:0] vin [3];
    logic [15:0] vexp [3];
    logic        oexp [3];
    int lat, bcnt; logic [15:0] rb; logic ro; bit tmo;
    vin[0] = 14'd10000; vexp[0] = 16'hFFFF; oexp[0] = 1'b1;
    vin[1] = 14'd16383; vexp[1] = 16'hFFFF; oexp[1] = 1'b1;
    vin[2] = 14'd42;    vexp[2] = 16'h0042; oexp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_conv(vin[i], lat, bcnt, rb, ro, tmo);
      total++; if (tmo) begin bad++; $display("FAIL ovf_timeout bin=%0d got=no_done exp=done", vin[i]); end
      total++; if (rb !== vexp[i]) begin bad++; $display("FAIL ovf_bcd bin=%0d got=%h exp=%h", vin[i], rb, vexp[i]); end
      total++; if (ro !== oexp[i]) begin bad++; $display("FAIL ovf_flag bin=%0d got=%0b exp=%0b", vin[i], ro, oexp[i]); end
      total++; if (lat !== 15) begin bad++; $display("FAIL ovf_latency bin=%0d got=%0d exp=15", vin[i], lat); end
    end
  endtask

  task automatic test_ignore_start;
    int dones; logic [15:0] rb; logic ro;
    dones = 0; rb = 16'h0000; ro = 1'b1;
    @(negedge clock);
    start = 1'b1;
    bin   = 14'd777;
    @(posedge clock); #1;
    start = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      if (done === 1'b1) begin
        dones++;
        rb = bcd;
        ro = ovf;
      end
      start = (e == 3 || e == 10) ? 1'b1 : 1'b0;
      if (e >= 2 && e < 14) bin = 14'd1;
      @(posedge clock); #1;
    end
    start = 1'b0;
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    total++; if (rb !== 16'h0777) begin bad++; $display("FAIL ignore_bcd got=%h exp=0777", rb); end
    total++; if (ro !== 1'b0) begin bad++; $display("FAIL ignore_ovf got=%0b exp=0", ro); end
  endtask

  task automatic test_back_to_back;
    int cyc; logic [15:0] expv;
    @(negedge clock);
    start = 1'b1;
    bin   = 14'd0;
    for (int i = 0; i <= 20; i++) begin
      cyc = 0;
      do begin
        @(posedge clock); #1;
        cyc++;
      end while (done !== 1'b1 && cyc < 40);
      expv = 16'(((i / 10) << 4) | (i % 10));
      total++; if (cyc !== 15) begin bad++; $display("FAIL b2b_period idx=%0d got=%0d exp=15", i, cyc); end
      total++; if (bcd !== expv) begin bad++; $display("FAIL b2b_bcd idx=%0d got=%h exp=%h", i, bcd, expv); end
      if (cyc >= 40) break;
      if (i == 20) start = 1'b0;
      else bin = 14'(i + 1);
    end
    start = 1'b0;
    @(posedge clock); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_stop got=%0b exp=0", done); end
  endtask

  task automatic test_reset_abort;
    int dones, lat, bcnt; logic [15:0] rb; logic ro; bit tmo;
    dones = 0;
    @(negedge clock);
    start = 1'b1;
    bin   = 14'd8888;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clock); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL abort_bcd got=%h exp=0000", bcd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    @(negedge clock);
    rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clock); #1;
      if (done === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    total++; if (bcd !== 16'h0000) begin bad++; $display("FAIL abort_bcd_after got=%h exp=0000", bcd); end
    do_conv(14'd31, lat, bcnt, rb, ro, tmo);
    total++; if (tmo) begin bad++; $display("FAIL abort_next_timeout got=no_done exp=done"); end
    total++; if (rb !== 16'h0031) begin bad++; $display("FAIL abort_next_bcd got=%h exp=0031", rb); end
    total++; if (ro !== 1'b0) begin bad++; $display("FAIL abort_next_ovf got=%0b exp=0", ro); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zero();
    test_values();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
